// File: rtl/apb_requester_engine_pkg.sv
// Shared APB types for requester/completer blocks: request and response records
// exchanged between a local controller and the APB bus engine.
package apb_requester_engine_pkg;

    localparam int APB_DATA_WIDTH     = 16;
    localparam int APB_MAX_ADDR_WIDTH = 32;

    typedef struct packed {
        logic                          write;
        logic [APB_MAX_ADDR_WIDTH-1:0] addr;
        logic [APB_DATA_WIDTH-1:0]     wdata;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } apb_resp_t;

endpackage

// File: rtl/apb_requester_engine.sv
// Single-outstanding APB3 requester: valid/ready request in, SETUP/ACCESS on the bus,
// registered response out, with a per-transaction ACCESS-phase timeout.
module apb_requester_engine
    import apb_requester_engine_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  resp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);

    if (DATA_WIDTH != APB_DATA_WIDTH) begin : g_width_check
        $error("apb_requester_engine supports DATA_WIDTH == 16 only");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    apb_resp_t        resp_q;
    logic             accept;
    logic             timeout_hit;

    assign accept      = req_valid && req_ready;
    // Terminal count is reached in the T-th ACCESS cycle without pready.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: defaults come first so no path through the block leaves a signal unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            cnt       <= '0;
            resp_q    <= '0;
        end else begin
            req_ready <= (state_next == IDLE);
            if (accept) begin
                pwrite <= req_write;
                paddr  <= req_addr;
                pwdata <= req_wdata;
            end
            if (state == SETUP) begin
                cnt <= '0;
            end else if (state == ACCESS && !pready && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            // pready has priority over a coincident terminal count.
            if (state == ACCESS) begin
                if (pready) begin
                    resp_q.rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                    resp_q.err     <= pslverr;
                    resp_q.timeout <= 1'b0;
                end else if (timeout_hit) begin
                    resp_q.rdata   <= '0;
                    resp_q.err     <= 1'b1;
                    resp_q.timeout <= 1'b1;
                end
            end
        end
    end

    assign psel         = (state == SETUP) || (state == ACCESS);
    assign penable      = (state == ACCESS);
    assign resp_valid   = (state == RESP);
    assign resp_rdata   = resp_q.rdata;
    assign resp_err     = resp_q.err;
    assign resp_timeout = resp_q.timeout;

endmodule

// File: tb/tb_apb_requester_engine.sv
// Scoreboard bench for apb_requester_engine: a wait-state/error-configurable APB completer,
// expected responses queued at request handshake and compared when the response is consumed.
module tb_apb_requester_engine;
    import apb_requester_engine_pkg::*;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          resp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready = 1'b0;
    logic [DW-1:0] prdata = '0;
    logic          pslverr = 1'b0;

    apb_requester_engine #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .resp_timeout(resp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        logic      write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        apb_resp_t resp;
        int        latency;
        int        pen;
    } exp_t;

    exp_t sb[$];

    // Completer configuration for the next request, and the copy latched for the active one.
    int        cfg_wait = 0;
    logic      cfg_err = 1'b0;
    logic [15:0] cfg_prdata = '0;
    int        act_wait = 0;
    logic      act_err = 1'b0;
    logic [15:0] act_prdata = '0;

    function automatic exp_t model(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                   input int ws, input logic e, input logic [15:0] pr);
        exp_t x;
        x.write        = w;
        x.addr         = a;
        x.wdata        = d;
        x.resp.timeout = (ws >= TO);
        x.resp.err     = x.resp.timeout || e;
        x.resp.rdata   = (!w && !x.resp.err) ? pr : 16'h0;
        x.latency      = x.resp.timeout ? 2 + TO : 3 + ws;
        x.pen          = x.resp.timeout ? TO : ws + 1;
        return x;
    endfunction

    // APB completer: pready asserted in ACCESS cycle number act_wait (0-based).
    int k = 0;
    always @(negedge clk) begin
        if (rst) begin
            k      = 0;
            pready = 1'b0;
        end else if (psel && penable) begin
            pready = (k == act_wait);
            k++;
        end else begin
            k      = 0;
            pready = 1'b0;
        end
        pslverr = act_err;
        prdata  = act_prdata;
    end

    int          acc_cyc = 0;
    int          pen_cnt = 0;
    bit          resp_seen = 1'b0;
    logic [17:0] held = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) begin
                sb.push_back(model(req_write, req_addr, req_wdata, cfg_wait, cfg_err, cfg_prdata));
                act_wait   = cfg_wait;
                act_err    = cfg_err;
                act_prdata = cfg_prdata;
                acc_cyc    = cyc;
                pen_cnt    = 0;
                resp_seen  = 1'b0;
            end
            if (psel && sb.size() > 0) begin
                if (!penable) begin
                    check("setup_cycle", cyc - acc_cyc, 1);
                end else begin
                    pen_cnt++;
                    if (pen_cnt == 1) check("access_cycle", cyc - acc_cyc, 2);
                end
                check("apb_fields", {pwrite, paddr, pwdata}, {sb[0].write, sb[0].addr, sb[0].wdata});
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_resp", resp_valid, 0);
                end else begin
                    check("psel_in_resp", {psel, penable}, 0);
                    check("req_ready_in_resp", req_ready, 0);
                    if (!resp_seen) begin
                        resp_seen = 1'b1;
                        held      = {resp_rdata, resp_err, resp_timeout};
                        check("resp_latency", cyc - acc_cyc, sb[0].latency);
                        check("penable_cycles", pen_cnt, sb[0].pen);
                    end else begin
                        check("resp_stable", {resp_rdata, resp_err, resp_timeout}, held);
                    end
                    if (resp_ready) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("resp_rdata", resp_rdata, e.resp.rdata);
                        check("resp_err", resp_err, e.resp.err);
                        check("resp_timeout", resp_timeout, e.resp.timeout);
                    end
                end
            end
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int ws, input logic e, input logic [15:0] pr, output int acc);
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        cfg_wait   = ws;
        cfg_err    = e;
        cfg_prdata = pr;
        req_valid  = 1'b1;
        acc        = -1;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            @(negedge clk);
            if (req_ready) acc = cyc;
        end
        check("req_accepted", acc >= 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        bit seen;

        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_ctrl", {psel, penable, resp_valid, resp_err, resp_timeout}, 0);
        check("rst_data", {pwrite, paddr, pwdata}, 0);
        check("rst_rdata", resp_rdata, 0);
        #22 rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_req_ready", req_ready, 1);

        send(1'b0, 12'h040, 16'h0000, 0, 1'b0, 16'hBEEF, a1);
        drain();
        send(1'b1, 12'h00C, 16'h1A5F, 3, 1'b0, 16'h7777, a1);
        drain();
        send(1'b0, 12'h0FC, 16'h0000, 0, 1'b1, 16'h1234, a1);
        drain();
        send(1'b0, 12'h010, 16'h0000, 20, 1'b0, 16'hCAFE, a1);
        drain();
        send(1'b0, 12'h020, 16'h0000, TO - 1, 1'b0, 16'h5A5A, a1);
        drain();
        send(1'b1, 12'h3A4, 16'hF00D, 1, 1'b0, 16'h1111, a1);
        drain();
        send(1'b1, 12'hFFF, 16'hAAAA, 2, 1'b1, 16'h2222, a1);
        drain();

        resp_ready = 1'b0;
        send(1'b0, 12'h055, 16'h0000, 0, 1'b0, 16'h3C3C, a1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = resp_valid;
        end
        check("bp_resp_valid", seen, 1);
        repeat (5) @(posedge clk);
        #1;
        resp_ready = 1'b1;
        drain();

        send(1'b0, 12'h100, 16'h0000, 0, 1'b0, 16'h0101, a1);
        send(1'b0, 12'h104, 16'h0000, 0, 1'b0, 16'h0202, a2);
        check("b2b_spacing", a2 - a1, 4);
        drain();

        send(1'b0, 12'h200, 16'h0000, 20, 1'b0, 16'h9999, a1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = psel && penable;
        end
        check("mid_access_reached", seen, 1);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_ctrl", {psel, penable, resp_valid, req_ready}, 0);
        check("mid_rst_data", {pwrite, paddr, pwdata}, 0);
        check("mid_rst_resp", {resp_rdata, resp_err, resp_timeout}, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", req_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_no_resp", {resp_valid, psel}, 0);

        send(1'b0, 12'h040, 16'h0000, 2, 1'b0, 16'h4321, a1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
